team_06_lcd_sequencer: RTL and testbench

- Sits between the display FSM and the byte-level I2C master that drives the PCF8574 LCD backpack.
- Accepts one 6-bit LCD nibble command at a time ({RS, RW, DB7..DB4}) and expands it into two backpack bytes: EN high, then EN low.
- Issues each byte to the I2C master, then waits the HD44780 execution delay.
- Pulses ready when the command is complete, or commsError on NACK/timeout.

---
 rtl/team_06_lcd_sequencer.sv | 165 ++++++++++++++++
 tb/tb_team_06_lcd_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/team_06_lcd_sequencer.sv
// Expands 6-bit HD44780 nibble commands into PCF8574 backpack byte pairs (EN high, EN low),
// issues them to a byte-level I2C master and waits the execution delay. Macro: TEAM_06_LCD_BACKLIGHT_EN.
module team_06_lcd_sequencer #(
  parameter int SHORT_DELAY = 400,
  parameter int LONG_DELAY  = 16000,
  parameter int ACK_TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       rst,
`ifdef TEAM_06_LCD_BACKLIGHT_EN
  input  logic       backlight,
`endif
  input  logic       trans,
  input  logic [5:0] lcdOut,
  output logic       ready,
  output logic       commsError,
  output logic       busy,
  output logic       i2c_req,
  output logic [7:0] i2c_data,
  input  logic       i2c_done,
  input  logic       i2c_nack
);

  localparam int MAX_DELAY = (LONG_DELAY > SHORT_DELAY) ? LONG_DELAY : SHORT_DELAY;
  localparam int HW = $clog2(MAX_DELAY + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [HW-1:0] SHORT_LOAD = HW'(SHORT_DELAY - 1);
  localparam logic [HW-1:0] LONG_LOAD  = HW'(LONG_DELAY - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(ACK_TIMEOUT - 1);
`ifdef TEAM_06_LCD_BACKLIGHT_EN
  localparam logic [7:0] DATA_RST = 8'h00;
`else
  localparam logic [7:0] DATA_RST = 8'h08;
`endif

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEND_HI = 3'd1,
    WAIT_HI = 3'd2,
    SEND_LO = 3'd3,
    WAIT_LO = 3'd4,
    HOLD    = 3'd5,
    DONE    = 3'd6,
    ERR     = 3'd7
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [5:0]      cmd_q;
  logic            phase;
  logic [3:0]      prev_hi;
  logic [HW-1:0]   hold_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic            long_sel;
  logic            send_next;
  logic [5:0]      src_cmd;
  logic            src_bl;
  logic [7:0]      data_next;
`ifdef TEAM_06_LCD_BACKLIGHT_EN
  logic            bl_q;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (trans) state_next = SEND_HI; else state_next = IDLE;
      SEND_HI: state_next = WAIT_HI;
      WAIT_HI: begin
        if (i2c_done)                state_next = i2c_nack ? ERR : SEND_LO;
        else if (tmo_cnt == TMO_LAST) state_next = ERR;
        else                         state_next = WAIT_HI;
      end
      SEND_LO: state_next = WAIT_LO;
      WAIT_LO: begin
        if (i2c_done)                state_next = i2c_nack ? ERR : HOLD;
        else if (tmo_cnt == TMO_LAST) state_next = ERR;
        else                         state_next = WAIT_LO;
      end
      HOLD:    if (hold_cnt == {HW{1'b0}}) state_next = DONE; else state_next = HOLD;
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from state_next, so the byte is built from lcdOut while cmd_q is still loading
  always_comb begin
    src_cmd = (state == IDLE) ? lcdOut : cmd_q;
`ifdef TEAM_06_LCD_BACKLIGHT_EN
    src_bl  = (state == IDLE) ? backlight : bl_q;
`else
    src_bl  = 1'b1;
`endif
    send_next = (state_next == SEND_HI) || (state_next == SEND_LO);
    data_next = {src_cmd[3:0], src_bl, (state_next == SEND_HI), src_cmd[4], src_cmd[5]};
    // Clear-display / return-home: low nibble 1..3 after a zero high nibble, instruction register
    long_sel  = phase && !cmd_q[5] && (prev_hi == 4'b0000) &&
                (cmd_q[3:2] == 2'b00) && (cmd_q[1:0] != 2'b00);
  end

  // Command latch, nibble phase, timeout and hold counters
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q    <= 6'b000000;
      phase    <= 1'b0;
      prev_hi  <= 4'b0000;
      hold_cnt <= {HW{1'b0}};
      tmo_cnt  <= {TW{1'b0}};
`ifdef TEAM_06_LCD_BACKLIGHT_EN
      bl_q     <= 1'b0;
`endif
    end else begin
      if (state == IDLE && trans) begin
        cmd_q <= lcdOut;
`ifdef TEAM_06_LCD_BACKLIGHT_EN
        bl_q  <= backlight;
`endif
      end
      case (state)
        SEND_HI, SEND_LO: tmo_cnt <= {TW{1'b0}};
        WAIT_HI, WAIT_LO: tmo_cnt <= tmo_cnt + TW'(1);
        default:          tmo_cnt <= tmo_cnt;
      endcase
      if (state == WAIT_LO && state_next == HOLD) begin
        hold_cnt <= long_sel ? LONG_LOAD : SHORT_LOAD;
      end else if (state == HOLD && hold_cnt != {HW{1'b0}}) begin
        hold_cnt <= hold_cnt - HW'(1);
      end
      if (state == DONE) begin
        phase <= ~phase;
        if (!phase) prev_hi <= cmd_q[3:0];
      end else if (state == ERR) begin
        phase <= 1'b0;
      end
    end
  end

  // Registered handshake and byte outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      ready      <= 1'b0;
      commsError <= 1'b0;
      busy       <= 1'b0;
      i2c_req    <= 1'b0;
      i2c_data   <= DATA_RST;
    end else begin
      ready      <= (state_next == DONE);
      commsError <= (state_next == ERR);
      busy       <= (state_next != IDLE);
      i2c_req    <= send_next;
      if (send_next) i2c_data <= data_next;
    end
  end

endmodule

// File: tb/tb_team_06_lcd_sequencer.sv
// Directed self-checking bench for team_06_lcd_sequencer with a zero-wait I2C responder.
module tb_team_06_lcd_sequencer;

  logic       clk = 1'b0;
  logic       rst, trans, i2c_done, i2c_nack;
  logic [5:0] lcdOut;
  logic       ready, commsError, busy, i2c_req;
  logic [7:0] i2c_data;
`ifdef TEAM_06_LCD_BACKLIGHT_EN
  logic       backlight;
  localparam logic [7:0] RST_DATA = 8'h00;
`else
  localparam logic [7:0] RST_DATA = 8'h08;
`endif

  int tests = 0;
  int fails = 0;
  int ready_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  always #5 clk = ~clk;

  team_06_lcd_sequencer dut (
    .clk(clk), .rst(rst),
`ifdef TEAM_06_LCD_BACKLIGHT_EN
    .backlight(backlight),
`endif
    .trans(trans), .lcdOut(lcdOut), .ready(ready), .commsError(commsError),
    .busy(busy), .i2c_req(i2c_req), .i2c_data(i2c_data),
    .i2c_done(i2c_done), .i2c_nack(i2c_nack)
  );

  always @(negedge clk) begin
    if (ready === 1'b1) ready_cnt++;
    if (commsError === 1'b1) err_cnt++;
    if (ready === 1'b1 && commsError === 1'b1) both_cnt++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wait for a byte request, check it, then answer with one done pulse in the WAIT state
  task automatic expect_byte(input string tag, input logic [7:0] exp, input logic nack, input logic drop);
    int n;
    n = 0;
    while (i2c_req !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    chk({tag, "_req"}, {31'd0, i2c_req}, 32'd1);
    chk({tag, "_data"}, {24'd0, i2c_data}, {24'd0, exp});
    tick;
    if (drop) trans = 1'b0;
    i2c_done = 1'b1;
    i2c_nack = nack;
    tick;
    i2c_done = 1'b0;
    i2c_nack = 1'b0;
  endtask

  // Count cycles from the edge that captured the last done until ready rises
  task automatic expect_ready(input string tag, input int delay, input logic [5:0] nxt);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < delay + 100) begin
      tick;
      n++;
    end
    chk({tag, "_lat"}, n, delay);
    lcdOut = nxt;
    tick;
    chk({tag, "_pulse"}, {31'd0, ready}, 32'd0);
  endtask

  initial begin
    int n;
    int rc;
    rst = 1'b1; trans = 1'b0; lcdOut = 6'b000000; i2c_done = 1'b0; i2c_nack = 1'b0;
`ifdef TEAM_06_LCD_BACKLIGHT_EN
    backlight = 1'b1;
`endif
    tick; tick;
    rst = 1'b0;
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_err",   {31'd0, commsError}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_req",   {31'd0, i2c_req}, 32'd0);
    chk("rst_data",  {24'd0, i2c_data}, {24'd0, RST_DATA});

    // Data write 'L' high nibble
    lcdOut = 6'b100100; trans = 1'b1; tick; trans = 1'b0;
    chk("L_busy", {31'd0, busy}, 32'd1);
    expect_byte("L_hi", 8'h4D, 1'b0, 1'b0);
    expect_byte("L_lo", 8'h49, 1'b0, 1'b0);
    expect_ready("L", 400, lcdOut);

    // Low nibble 0001 after a non-zero high nibble stays short
    lcdOut = 6'b000001; trans = 1'b1; tick; trans = 1'b0;
    expect_byte("nl_hi", 8'h1C, 1'b0, 1'b0);
    expect_byte("nl_lo", 8'h18, 1'b0, 1'b0);
    expect_ready("nl", 400, lcdOut);

    // Clear display pair from a fresh phase
    rst = 1'b1; tick; rst = 1'b0;
    lcdOut = 6'b000000; trans = 1'b1; tick; trans = 1'b0;
    expect_byte("clr0_hi", 8'h0C, 1'b0, 1'b0);
    expect_byte("clr0_lo", 8'h08, 1'b0, 1'b0);
    expect_ready("clr0", 400, lcdOut);
    lcdOut = 6'b000001; trans = 1'b1; tick; trans = 1'b0;
    expect_byte("clr1_hi", 8'h1C, 1'b0, 1'b0);
    expect_byte("clr1_lo", 8'h18, 1'b0, 1'b0);
    expect_ready("clr1", 16000, lcdOut);

    // NACK on the second nibble's first byte resets the phase
    lcdOut = 6'b000000; trans = 1'b1; tick; trans = 1'b0;
    expect_byte("pre_hi", 8'h0C, 1'b0, 1'b0);
    expect_byte("pre_lo", 8'h08, 1'b0, 1'b0);
    expect_ready("pre", 400, lcdOut);
    lcdOut = 6'b000001; trans = 1'b1; tick; trans = 1'b0;
    expect_byte("nack_hi", 8'h1C, 1'b1, 1'b0);
    chk("nack_err",   {31'd0, commsError}, 32'd1);
    chk("nack_ready", {31'd0, ready}, 32'd0);
    tick;
    chk("nack_err_pulse", {31'd0, commsError}, 32'd0);
    chk("nack_busy",      {31'd0, busy}, 32'd0);
    chk("nack_no_lo_req", {31'd0, i2c_req}, 32'd0);
    lcdOut = 6'b000001; trans = 1'b1; tick; trans = 1'b0;
    expect_byte("retry_hi", 8'h1C, 1'b0, 1'b0);
    expect_byte("retry_lo", 8'h18, 1'b0, 1'b0);
    expect_ready("retry", 400, lcdOut);

    // Timeout: no done at all
    lcdOut = 6'b100100; trans = 1'b1; tick; trans = 1'b0;
    chk("to_req",  {31'd0, i2c_req}, 32'd1);
    chk("to_data", {24'd0, i2c_data}, 32'h0000_004D);
    tick;
    n = 0;
    while (commsError !== 1'b1 && n < 5000) begin
      tick;
      n++;
    end
    chk("to_lat", n, 32'd4096);
    tick;
    chk("to_err_pulse", {31'd0, commsError}, 32'd0);
    chk("to_busy",      {31'd0, busy}, 32'd0);

    // trans dropped during WAIT_LO
    lcdOut = 6'b110101; trans = 1'b1; tick;
    expect_byte("mid_hi", 8'h5F, 1'b0, 1'b0);
    expect_byte("mid_lo", 8'h5B, 1'b0, 1'b1);
    expect_ready("mid", 400, lcdOut);

    // Reset while in HOLD
    lcdOut = 6'b100100; trans = 1'b1; tick; trans = 1'b0;
    expect_byte("hr_hi", 8'h4D, 1'b0, 1'b0);
    expect_byte("hr_lo", 8'h49, 1'b0, 1'b0);
    repeat (10) tick;
    chk("hr_busy_hold", {31'd0, busy}, 32'd1);
    rc = ready_cnt;
    rst = 1'b1; tick; rst = 1'b0;
    chk("hr_ready", {31'd0, ready}, 32'd0);
    chk("hr_err",   {31'd0, commsError}, 32'd0);
    chk("hr_busy",  {31'd0, busy}, 32'd0);
    chk("hr_req",   {31'd0, i2c_req}, 32'd0);
    chk("hr_data",  {24'd0, i2c_data}, {24'd0, RST_DATA});
    repeat (500) tick;
    chk("hr_no_ready", ready_cnt, rc);

    // Back-to-back with trans held and lcdOut updated on ready
    lcdOut = 6'b100110; trans = 1'b1; tick;
    expect_byte("b2b_a_hi", 8'h6D, 1'b0, 1'b0);
    expect_byte("b2b_a_lo", 8'h69, 1'b0, 1'b0);
    expect_ready("b2b_a", 400, 6'b101000);
    expect_byte("b2b_b_hi", 8'h8D, 1'b0, 1'b1);
    expect_byte("b2b_b_lo", 8'h89, 1'b0, 1'b0);
    expect_ready("b2b_b", 400, lcdOut);
    repeat (5) tick;
    chk("b2b_idle", {31'd0, busy}, 32'd0);

    chk("never_both",  both_cnt, 32'd0);
    chk("ready_total", ready_cnt, 32'd9);
    chk("err_total",   err_cnt, 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
